// File: rtl/nibble_loop_sequencer_if.sv
// Shared ALU command/control types and the op/result handshake bundle
// between the issue logic and the nibble-loop sequencer.
package nibble_loop_pkg;
    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_LSHFT = 4'd5,
        ALU_RSHFT = 4'd6,
        ALU_PASS  = 4'd7
    } AluCmd;

    typedef struct packed {
        AluCmd cmd;
        logic  carry_in;
        logic  carry_disable;
    } AluCtrl;
endpackage

interface nibble_loop_sequencer_if;
    import nibble_loop_pkg::*;

    logic        op_valid;
    logic        op_ready;
    AluCmd       op_cmd;
    logic [1:0]  op_size;
    logic        op_signed;
    logic [31:0] op_w1;
    logic [31:0] op_w2;

    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic        res_zero;
    logic        res_neg;
    logic        res_err;

    // Issuer / consumer side
    modport master (
        output op_valid, op_cmd, op_size, op_signed, op_w1, op_w2, res_ready,
        input  op_ready, res_valid, res_data, res_zero, res_neg, res_err
    );

    // Sequencer side
    modport slave (
        input  op_valid, op_cmd, op_size, op_signed, op_w1, op_w2, res_ready,
        output op_ready, res_valid, res_data, res_zero, res_neg, res_err
    );
endinterface

// File: rtl/nibble_loop_sequencer.sv
// Issue/retire stage for the nibble-loop ALU: accepts one op, preloads the
// loop, runs it until idle (or timeout) and holds the result until consumed.
module nibble_loop_sequencer
    import nibble_loop_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    nibble_loop_sequencer_if.slave bus,
    output logic        loop_perm_to_count,
    output logic [2:0]  loop_nibbles_number,
    output AluCtrl      loop_ctrl,
    output logic        word2_is_negative,
    output logic [31:0] word1,
    output logic [31:0] word2,
    output logic [31:0] preinit_result,
    input  logic        busy,
    input  logic [31:0] result
);
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_INIT, S_RUN, S_DONE} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [CW-1:0] r_cnt;

    logic        w_op_ready;
    logic        w_perm;
    logic        w_accept;
    logic        w_capture;
    logic        w_timeout;
    logic        w_retire;

    logic [2:0]  w_nib;
    logic        w_sign_bit;
    logic [31:0] w_mask;

    logic [2:0]  r_nib;
    AluCtrl      r_ctrl;
    logic        r_w2_neg;
    logic [31:0] r_w1;
    logic [31:0] r_w2;
    logic [31:0] r_preinit;

    logic        r_res_valid;
    logic [31:0] r_res_data;
    logic        r_res_zero;
    logic        r_res_neg;
    logic        r_res_err;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state and handshake decode; r_cnt counts completed RUN cycles, so
    // r_cnt==0 is the first RUN cycle where busy is not yet meaningful
    always_comb begin
        w_next     = r_state;
        w_op_ready = 1'b0;
        w_perm     = 1'b0;
        w_accept   = 1'b0;
        w_capture  = 1'b0;
        w_timeout  = 1'b0;
        w_retire   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_op_ready = 1'b1;
                if (bus.op_valid) begin
                    w_accept = 1'b1;
                    w_next   = S_INIT;
                end
            end
            S_INIT: w_next = S_RUN;
            S_RUN: begin
                w_perm = 1'b1;
                if ((r_cnt != '0) && !busy) begin
                    w_capture = 1'b1;
                    w_next    = S_DONE;
                end else if (r_cnt == LAST) begin
                    w_capture = 1'b1;
                    w_timeout = 1'b1;
                    w_next    = S_DONE;
                end
            end
            S_DONE: begin
                w_perm = 1'b1;
                if (bus.res_ready) begin
                    w_retire = 1'b1;
                    w_next   = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Operand size to index of last nibble
    always_comb begin
        case (bus.op_size)
            2'd0:    w_nib = 3'd1;
            2'd1:    w_nib = 3'd3;
            2'd2:    w_nib = 3'd7;
            default: w_nib = 3'd0;
        endcase
    end

    // Result width mask for the registered nibble count
    always_comb begin
        case (r_nib)
            3'd0:    w_mask = 32'h0000_000f;
            3'd1:    w_mask = 32'h0000_00ff;
            3'd3:    w_mask = 32'h0000_ffff;
            default: w_mask = 32'hffff_ffff;
        endcase
    end

    // Top bit of the selected width sits at 4*N+3 = {N, 2'b11}
    assign w_sign_bit = bus.op_w2[{w_nib, 2'b11}];

    // Operand/control capture, timeout counter and result capture
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_nib       <= '0;
            r_ctrl      <= '0;
            r_w2_neg    <= 1'b0;
            r_w1        <= '0;
            r_w2        <= '0;
            r_preinit   <= '0;
            r_cnt       <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_zero  <= 1'b0;
            r_res_neg   <= 1'b0;
            r_res_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_nib         <= w_nib;
                r_ctrl.cmd    <= bus.op_cmd;
                r_ctrl.carry_in      <= 1'b0;
                r_ctrl.carry_disable <= 1'b0;
                r_w2_neg      <= bus.op_signed & w_sign_bit;
                r_w1          <= bus.op_w1;
                r_w2          <= bus.op_w2;
                r_preinit     <= (bus.op_cmd == ALU_RSHFT) ? '0 : bus.op_w1;
            end
            if (r_state == S_INIT) r_cnt <= '0;
            else if (r_state == S_RUN && !w_capture) r_cnt <= r_cnt + 1'b1;
            if (w_capture) begin
                r_res_valid <= 1'b1;
                r_res_data  <= result;
                r_res_zero  <= ((result & w_mask) == '0);
                r_res_neg   <= result[{r_nib, 2'b11}];
                r_res_err   <= w_timeout;
            end
            if (w_retire) begin
                r_res_valid <= 1'b0;
                r_res_err   <= 1'b0;
            end
        end
    end

    assign bus.op_ready        = w_op_ready;
    assign bus.res_valid       = r_res_valid;
    assign bus.res_data        = r_res_data;
    assign bus.res_zero        = r_res_zero;
    assign bus.res_neg         = r_res_neg;
    assign bus.res_err         = r_res_err;

    assign loop_perm_to_count  = w_perm;
    assign loop_nibbles_number = r_nib;
    assign loop_ctrl           = r_ctrl;
    assign word2_is_negative   = r_w2_neg;
    assign word1               = r_w1;
    assign word2               = r_w2;
    assign preinit_result      = r_preinit;
endmodule
